// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the generic pipeline stage register: occupancy
// encodings, the zero fill bit and a helper for the registered ready.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_BUSY  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam logic Zero = 1'b0;

  // The stage can take a new entry whenever it will not be holding two.
  function automatic logic ready_for(input occ_e nxt);
    return nxt != OCC_FULL;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all-ones, cleared by rst.
// Latency 1 cycle from inc to count; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready stage register with a two-entry skid buffer, flush and bubble counter.
// Latency 1 cycle; in_ready is registered and falls only once both entries are held.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter bit ZERO_ON_EMPTY = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [DATA_W-1:0] ZeroData = {DATA_W{Zero}};

  occ_e              r_occ;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              r_in_rdy;

  occ_e              w_occ_nxt;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              w_acc;
  logic              w_rel;
  logic              w_out_vld;

  assign w_out_vld = (r_occ != OCC_EMPTY);
  assign w_acc     = in_valid & r_in_rdy;
  assign w_rel     = w_out_vld & out_ready;

  always_comb begin
    w_occ_nxt  = r_occ;
    w_main_nxt = r_main;
    w_skid_nxt = r_skid;
    // Flush drops any same-cycle input; a same-cycle release has still happened downstream.
    if (flush) begin
      w_occ_nxt  = OCC_EMPTY;
      w_main_nxt = ZeroData;
      w_skid_nxt = ZeroData;
    end else begin
      case (r_occ)
        OCC_EMPTY: begin
          if (w_acc) begin
            w_main_nxt = in_data;
            w_occ_nxt  = OCC_BUSY;
          end
        end
        OCC_BUSY: begin
          if (w_acc && w_rel) begin
            w_main_nxt = in_data;
          end else if (w_acc) begin
            w_skid_nxt = in_data;
            w_occ_nxt  = OCC_FULL;
          end else if (w_rel) begin
            w_occ_nxt = OCC_EMPTY;
            if (ZERO_ON_EMPTY) begin
              w_main_nxt = ZeroData;
            end
          end
        end
        OCC_FULL: begin
          if (w_rel) begin
            w_main_nxt = r_skid;
            w_skid_nxt = ZeroData;
            w_occ_nxt  = OCC_BUSY;
          end
        end
        default: begin
          w_occ_nxt  = OCC_EMPTY;
          w_main_nxt = ZeroData;
          w_skid_nxt = ZeroData;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= OCC_EMPTY;
      r_main   <= ZeroData;
      r_skid   <= ZeroData;
      r_in_rdy <= 1'b1;
    end else begin
      r_occ    <= w_occ_nxt;
      r_main   <= w_main_nxt;
      r_skid   <= w_skid_nxt;
      r_in_rdy <= ready_for(w_occ_nxt);
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = w_out_vld;
  assign out_data  = (ZERO_ON_EMPTY && !w_out_vld) ? ZeroData : r_main;
  assign occupancy = r_occ;

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_ready & ~w_out_vld),
    .count(bubble_cnt)
  );

endmodule
